// File: rtl/solar_tracker_pkg.sv
// Shared types and constants for the solar tracker stepper.
package solar_tracker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_REV  = 2'd2
   } state_e;

   // Coil patterns indexed by phase 0..7; element [0] is the rightmost entry.
   // Even indices are two-coil states, so full-step mode walks only even entries.
   localparam logic [7:0][3:0] PHASE_TABLE = {
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001
   };

   // Width of a half-step position counter able to hold 0..2*day_hours*steps_per_hour.
   function automatic int pos_width(input int day_hours, input int steps_per_hour);
      return $clog2(2 * day_hours * steps_per_hour + 1);
   endfunction

endpackage

// File: rtl/solar_tracker_stepper_tod.sv
// Time-of-day counter: seconds/minutes/hours advanced by a 1 Hz enable,
// with a one-cycle strobe that is high while the freshly updated hour is visible.
module tod_counter #(
   parameter int SEC_PER_MIN   = 60,
   parameter int MIN_PER_HOUR  = 60,
   parameter int HOURS_PER_DAY = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1s,
   output logic [5:0] seconds,
   output logic [5:0] minutes,
   output logic [4:0] hours,
   output logic       hour_evt
);

   localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);
   localparam logic [5:0] MIN_LAST = 6'(MIN_PER_HOUR - 1);
   localparam logic [4:0] HR_LAST  = 5'(HOURS_PER_DAY - 1);

   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hr_q,  hr_d;
   logic       evt_q, evt_d;

   // Cascade the wraps: each tick bumps seconds, a seconds wrap bumps minutes, and so on.
   always_comb begin
      sec_d = sec_q;
      min_d = min_q;
      hr_d  = hr_q;
      evt_d = 1'b0;
      if (tick_1s) begin
         if (sec_q == SEC_LAST) begin
            sec_d = 6'd0;
            if (min_q == MIN_LAST) begin
               min_d = 6'd0;
               evt_d = 1'b1;
               hr_d  = (hr_q == HR_LAST) ? 5'd0 : hr_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   // Time registers; the strobe is registered alongside hours so both appear together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_q <= 6'd0;
         min_q <= 6'd0;
         hr_q  <= 5'd0;
         evt_q <= 1'b0;
      end else begin
         sec_q <= sec_d;
         min_q <= min_d;
         hr_q  <= hr_d;
         evt_q <= evt_d;
      end
   end

   assign seconds  = sec_q;
   assign minutes  = min_q;
   assign hours    = hr_q;
   assign hour_evt = evt_q;

endmodule

// File: rtl/solar_tracker_stepper.sv
// Hourly solar tracker: time-of-day counter driving a 4-coil stepper sequencer
// with a one-deep request slot, forward moves each daytime hour and a return home.
module solar_tracker_stepper
   import solar_tracker_pkg::*;
#(
   parameter int SEC_PER_MIN    = 60,
   parameter int MIN_PER_HOUR   = 60,
   parameter int HOURS_PER_DAY  = 24,
   parameter int DAY_HOURS      = 12,
   parameter int STEPS_PER_HOUR = 8,
   parameter int STEP_DIV       = 4,
   parameter int HOLD           = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1s,
   input  logic       enable,
   input  logic       half_step,
   output logic [5:0] seconds,
   output logic [5:0] minutes,
   output logic [4:0] hours,
   output logic [3:0] coil,
   output logic       step_pulse,
   output logic       busy,
   output logic       dir,
   output logic       at_home,
   output logic       missed
);

   localparam int PW = pos_width(DAY_HOURS, STEPS_PER_HOUR);
   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PW-1:0] POS_MAX  = PW'(2 * DAY_HOURS * STEPS_PER_HOUR);
   localparam logic [PW-1:0] MOVE_LEN = PW'(2 * STEPS_PER_HOUR);
   localparam logic [PW-1:0] ONE_P    = PW'(1);
   localparam logic [PW-1:0] TWO_P    = PW'(2);
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
   localparam logic [4:0]    H_DAY    = 5'(DAY_HOURS);
   localparam logic [4:0]    H_RET    = 5'(DAY_HOURS + 1);

   logic hour_evt;

   tod_counter #(
      .SEC_PER_MIN  (SEC_PER_MIN),
      .MIN_PER_HOUR (MIN_PER_HOUR),
      .HOURS_PER_DAY(HOURS_PER_DAY)
   ) u_tod (
      .clk     (clk),
      .reset   (reset),
      .tick_1s (tick_1s),
      .seconds (seconds),
      .minutes (minutes),
      .hours   (hours),
      .hour_evt(hour_evt)
   );

   state_e        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [PW-1:0] rem_q, rem_d;
   logic [DW-1:0] div_q, div_d;
   logic          dir_q, dir_d;
   logic          mode_half_q, mode_half_d;
   logic          pend_vld_q, pend_vld_d;
   logic          pend_ret_q, pend_ret_d;
   logic          missed_q, missed_d;
   logic          pulse_q, pulse_d;

   logic          req_fwd, req_ret, new_req, can_launch;
   logic          launch_vld, launch_ret;
   logic [PW:0]   fwd_end;
   logic          step_full;
   logic [PW-1:0] step_pos;
   logic [2:0]    step_idx;

   // Request decode, pending slot arbitration, and the IDLE/FWD/REV sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pos_d       = pos_q;
      rem_d       = rem_q;
      div_d       = div_q;
      dir_d       = dir_q;
      mode_half_d = mode_half_q;
      pend_vld_d  = pend_vld_q;
      pend_ret_d  = pend_ret_q;
      missed_d    = missed_q;
      pulse_d     = 1'b0;
      launch_vld  = 1'b0;
      launch_ret  = 1'b0;

      req_fwd    = hour_evt && (hours != 5'd0) && (hours <= H_DAY);
      req_ret    = hour_evt && (hours == H_RET);
      new_req    = req_fwd || req_ret;
      can_launch = (state_q == ST_IDLE) && enable;

      // A held request always has priority; anything arriving while it is held is lost.
      if (pend_vld_q) begin
         if (new_req) begin
            missed_d = 1'b1;
         end
         if (can_launch) begin
            launch_vld = 1'b1;
            launch_ret = pend_ret_q;
            pend_vld_d = 1'b0;
         end
      end else if (new_req) begin
         if (can_launch) begin
            launch_vld = 1'b1;
            launch_ret = req_ret;
         end else begin
            pend_vld_d = 1'b1;
            pend_ret_d = req_ret;
         end
      end

      // Step mode may only change while parked at home.
      if ((state_q == ST_IDLE) && (pos_q == '0)) begin
         mode_half_d = half_step;
      end

      // Forward moves stop at the far end of travel.
      fwd_end = {1'b0, pos_q} + {1'b0, MOVE_LEN};

      // A full step falls back to a half step only if one half-step is left to go.
      step_full = !mode_half_q && (rem_q >= TWO_P);
      step_pos  = step_full ? TWO_P : ONE_P;
      step_idx  = step_full ? 3'd2 : 3'd1;

      case (state_q)
         ST_IDLE: begin
            if (launch_vld) begin
               if (launch_ret) begin
                  if (pos_q != '0) begin
                     state_d = ST_REV;
                     rem_d   = pos_q;
                     dir_d   = 1'b0;
                     div_d   = '0;
                  end
               end else begin
                  state_d = ST_FWD;
                  rem_d   = (fwd_end > {1'b0, POS_MAX}) ? (POS_MAX - pos_q) : MOVE_LEN;
                  dir_d   = 1'b1;
                  div_d   = '0;
               end
            end
         end
         ST_FWD, ST_REV: begin
            if (rem_q == '0) begin
               state_d = ST_IDLE;
            end else if (div_q == DIV_LAST) begin
               div_d   = '0;
               pulse_d = 1'b1;
               rem_d   = rem_q - step_pos;
               if (state_q == ST_FWD) begin
                  idx_d = idx_q + step_idx;
                  pos_d = pos_q + step_pos;
               end else begin
                  idx_d = idx_q - step_idx;
                  pos_d = pos_q - step_pos;
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state; reset declares the mechanism home with coils released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= 3'd0;
         pos_q       <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         dir_q       <= 1'b1;
         mode_half_q <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_ret_q  <= 1'b0;
         missed_q    <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pos_q       <= pos_d;
         rem_q       <= rem_d;
         div_q       <= div_d;
         dir_q       <= dir_d;
         mode_half_q <= mode_half_d;
         pend_vld_q  <= pend_vld_d;
         pend_ret_q  <= pend_ret_d;
         missed_q    <= missed_d;
         pulse_q     <= pulse_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign coil       = (busy || (HOLD != 0)) ? PHASE_TABLE[idx_q] : 4'b0000;
   assign step_pulse = pulse_q;
   assign dir        = dir_q;
   assign at_home    = (pos_q == '0);
   assign missed     = missed_q;

endmodule
